// File: rtl/unidad_fetch.sv
// =============================================================================
// Module      : unidad_fetch
// Description : Fetch stage ahead of a combinational instruction ROM. Holds the
//               PC, drives the ROM word address and registers IF/ID.
//               Optional macro HALT_DETECT_EN: 32'hFFFF_FFFF acts as halt.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module unidad_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 4,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [31:0]           redirect_pc_i,
    input  logic                  halt_i,
    output logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           instruction,
    output logic [31:0]           pc_o,
    output logic [31:0]           if_id_instr_o,
    output logic [31:0]           if_id_pc_o,
    output logic [31:0]           if_id_pc4_o,
    output logic                  if_id_valid_o,
    output logic                  halted_o,
    output logic                  misalign_o,
    output logic [CNT_WIDTH-1:0]  fetch_count_o
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          ifid_instr_q, ifid_instr_d;
    logic [31:0]          ifid_pc_q, ifid_pc_d;
    logic [31:0]          ifid_pc4_q, ifid_pc4_d;
    logic                 ifid_valid_q, ifid_valid_d;
    logic                 misalign_q, misalign_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [31:0]          w_pc4;
    logic                 w_halt_word;

    assign w_pc4 = pc_q + 32'd4;

`ifdef HALT_DETECT_EN
    assign w_halt_word = (instruction == 32'hFFFF_FFFF);
`else
    assign w_halt_word = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        misalign_d   = misalign_q;
        cnt_d        = cnt_q;

        // Redirect wins in both states and always flushes IF/ID.
        if (redirect_i) begin
            state_d      = ST_RUN;
            pc_d         = {redirect_pc_i[31:2], 2'b00};
            ifid_valid_d = 1'b0;
            if (redirect_pc_i[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (state_q == ST_HALTED) begin
            ifid_valid_d = 1'b0;
        end else if (halt_i) begin
            state_d      = ST_HALTED;
            ifid_valid_d = 1'b0;
        end else if (stall_i) begin
            state_d = ST_RUN;
        end else if (w_halt_word) begin
            state_d      = ST_HALTED;
            ifid_valid_d = 1'b0;
        end else begin
            ifid_instr_d = instruction;
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = w_pc4;
            ifid_valid_d = 1'b1;
            pc_d         = w_pc4;
            if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            ifid_instr_q <= 32'd0;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            misalign_q   <= misalign_d;
            cnt_q        <= cnt_d;
        end
    end

    // Word address wraps naturally by truncation of the PC.
    assign address       = pc_q[ADDR_WIDTH+1:2];
    assign pc_o          = pc_q;
    assign if_id_instr_o = ifid_instr_q;
    assign if_id_pc_o    = ifid_pc_q;
    assign if_id_pc4_o   = ifid_pc4_q;
    assign if_id_valid_o = ifid_valid_q;
    assign halted_o      = (state_q == ST_HALTED);
    assign misalign_o    = misalign_q;
    assign fetch_count_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_unidad_fetch.sv
// =============================================================================
// Module      : tb_unidad_fetch
// Description : Self-checking bench for unidad_fetch with a captured-word
//               scoreboard. Honours HALT_DETECT_EN when defined.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_unidad_fetch;

    localparam int CW = 4;

`ifdef HALT_DETECT_EN
    localparam bit HD = 1'b1;
`else
    localparam bit HD = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          stall_i;
    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic          halt_i;
    logic [3:0]    address;
    logic [31:0]   instruction;
    logic [31:0]   pc_o;
    logic [31:0]   if_id_instr_o;
    logic [31:0]   if_id_pc_o;
    logic [31:0]   if_id_pc4_o;
    logic          if_id_valid_o;
    logic          halted_o;
    logic          misalign_o;
    logic [CW-1:0] fetch_count_o;

    logic [31:0]   rom [16];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } cap_t;

    cap_t        sb[$];
    cap_t        last;
    logic [31:0] m_pc;
    logic        m_halted;
    logic        m_valid;
    logic        m_mis;
    logic [CW-1:0] m_cnt;

    unidad_fetch #(
        .RESET_PC   (32'h0000_0000),
        .ADDR_WIDTH (4),
        .CNT_WIDTH  (CW)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .address       (address),
        .instruction   (instruction),
        .pc_o          (pc_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_valid_o (if_id_valid_o),
        .halted_o      (halted_o),
        .misalign_o    (misalign_o),
        .fetch_count_o (fetch_count_o)
    );

    assign instruction = rom[address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = 32'd0;
        m_halted = 1'b0;
        m_valid  = 1'b0;
        m_mis    = 1'b0;
        m_cnt    = '0;
        last     = '0;
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},     64'(pc_o), 64'd0);
        check({tag, "_addr"},   64'(address), 64'd0);
        check({tag, "_instr"},  64'(if_id_instr_o), 64'd0);
        check({tag, "_ifpc"},   64'(if_id_pc_o), 64'd0);
        check({tag, "_ifpc4"},  64'(if_id_pc4_o), 64'd0);
        check({tag, "_valid"},  64'(if_id_valid_o), 64'd0);
        check({tag, "_halted"}, 64'(halted_o), 64'd0);
        check({tag, "_mis"},    64'(misalign_o), 64'd0);
        check({tag, "_cnt"},    64'(fetch_count_o), 64'd0);
    endtask

    // One clock: drive inputs, advance the expectation, then compare.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic hl);
        logic [31:0] w;
        cap_t        c;
        @(negedge clk);
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        halt_i        = hl;
        w = rom[m_pc[5:2]];
        if (rd) begin
            m_pc     = {rpc[31:2], 2'b00};
            m_valid  = 1'b0;
            m_halted = 1'b0;
            if (rpc[1:0] != 2'b00) m_mis = 1'b1;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (hl) begin
            m_halted = 1'b1;
            m_valid  = 1'b0;
        end else if (st) begin
            m_valid = m_valid;
        end else if (HD && w == 32'hFFFF_FFFF) begin
            m_halted = 1'b1;
            m_valid  = 1'b0;
        end else begin
            sb.push_back('{instr: w, pc: m_pc, pc4: m_pc + 32'd4});
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            c    = sb.pop_front();
            last = c;
        end
        check("ifid_instr", 64'(if_id_instr_o), 64'(last.instr));
        check("ifid_pc",    64'(if_id_pc_o),    64'(last.pc));
        check("ifid_pc4",   64'(if_id_pc4_o),   64'(last.pc4));
        check("valid",      64'(if_id_valid_o), 64'(m_valid));
        check("pc",         64'(pc_o),          64'(m_pc));
        check("address",    64'(address),       64'(m_pc[5:2]));
        check("halted",     64'(halted_o),      64'(m_halted));
        check("misalign",   64'(misalign_o),    64'(m_mis));
        check("count",      64'(fetch_count_o), 64'(m_cnt));
    endtask

    initial begin
        rst_n         = 1'b0;
        stall_i       = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        halt_i        = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 32'h11 * (i + 1);
        model_reset();
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch with a 3-cycle stall at pc 8
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Misaligned redirect concurrent with stall, then fetch word 7
        step(1, 1, 32'h0000_001E, 0);
        step(0, 0, 0, 0);

        // Halt; stall/halt ignored while halted; redirect to 0 resumes
        step(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(i[0], 0, 0, i[1]);
        step(0, 1, 32'h0000_0000, 0);
        step(0, 0, 0, 0);

        // Address wrap past word 15 and 32-bit PC wrap
        step(0, 1, 32'h0000_003C, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // All-ones word at word 5
        rom[5] = 32'hFFFF_FFFF;
        step(0, 1, 32'h0000_0010, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h0000_0018, 0);
        rom[5] = 32'h0000_0066;

        // Counter saturation
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);

        // Asynchronous reset in the middle of a stall
        step(1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
